chip_frame_buf: RTL and testbench



---
 rtl/chip_frame_buf_if.sv | 26 ++
 rtl/chip_frame_buf.sv | 167 ++++++++++++++++
 tb/tb_chip_frame_buf.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/chip_frame_buf_if.sv
// Sample-capture and host-read signal bundle for chip_frame_buf.
// The master modport belongs to the selector/host side; the slave modport belongs to the buffer.
interface chip_frame_buf_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic [15:0]         d1_data;
    logic                d1_vld;
    logic [6:0]          sel_path;
    logic [19:0]         cfg_len;
    logic                buf_rdy;
    logic                rd_en;
    logic [15:0]         rd_data;
    logic                rd_vld;
    logic [DEPTH_LOG2:0] rd_level;
    logic                ovf_err;

    modport master (
        output d1_data, d1_vld, sel_path, cfg_len, rd_en,
        input  buf_rdy, rd_data, rd_vld, rd_level, ovf_err
    );

    modport slave (
        input  d1_data, d1_vld, sel_path, cfg_len, rd_en,
        output buf_rdy, rd_data, rd_vld, rd_level, ovf_err
    );
endinterface

// File: rtl/chip_frame_buf.sv
// Frame capture buffer: stores triggered sample bursts as header + payload frames in a RAM.
// A frame becomes visible to the reader only once its header has been written.
module chip_frame_buf #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    chip_frame_buf_if.slave bus
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    function automatic logic [15:0] make_header(input logic [6:0] sel, input logic [7:0] seq);
        return {1'b1, sel, seq};
    endfunction

    state_t                  state_r;
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           wr_cmt_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [DEPTH_LOG2-1:0]   base_r;
    logic [6:0]              sel_q_r;
    logic [7:0]              seq_r;
    logic [19:0]             cnt_r;
    logic                    buf_rdy_r;
    logic                    ovf_err_r;
    logic                    rd_vld_r;
    logic [15:0]             rd_data_r;
    logic [15:0]             mem_r [0:DEPTH-1];

    logic [PW-1:0]           free_s;
    logic [PW-1:0]           rd_level_s;
    logic [20:0]             free_ext_s;
    logic [20:0]             need_s;
    logic                    fits_s;
    logic                    rd_acc_s;
    logic                    start_s;
    logic                    wr_en_s;
    logic [DEPTH_LOG2-1:0]   wr_addr_s;
    logic [15:0]             wr_data_s;

    assign free_s     = PW'(DEPTH) - (wr_ptr_r - rd_ptr_r);
    assign rd_level_s = wr_cmt_r - rd_ptr_r;
    assign free_ext_s = {{(21-PW){1'b0}}, free_s};
    assign need_s     = {1'b0, bus.cfg_len} + 21'd1;
    assign fits_s     = (bus.cfg_len != 20'd0) && (free_ext_s >= need_s);
    assign rd_acc_s   = bus.rd_en && (rd_level_s != {PW{1'b0}});
    assign start_s    = (state_r == ST_IDLE) && bus.d1_vld && buf_rdy_r;

    // RAM write-port selection: first sample skips the header slot, CLOSE fills it.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = wr_ptr_r[DEPTH_LOG2-1:0];
        wr_data_s = bus.d1_data;
        case (state_r)
            ST_IDLE: begin
                wr_en_s   = bus.d1_vld && buf_rdy_r;
                wr_addr_s = wr_ptr_r[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
            end
            ST_CAPT: begin
                wr_en_s = bus.d1_vld;
            end
            ST_CLOSE: begin
                wr_en_s   = 1'b1;
                wr_addr_s = base_r;
                wr_data_s = make_header(sel_q_r, seq_r);
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Frame capture FSM with registered ready and sticky overflow flag.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            wr_ptr_r  <= {PW{1'b0}};
            wr_cmt_r  <= {PW{1'b0}};
            base_r    <= {DEPTH_LOG2{1'b0}};
            sel_q_r   <= 7'd0;
            seq_r     <= 8'd0;
            cnt_r     <= 20'd0;
            buf_rdy_r <= 1'b0;
            ovf_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        sel_q_r  <= bus.sel_path;
                        base_r   <= wr_ptr_r[DEPTH_LOG2-1:0];
                        wr_ptr_r <= wr_ptr_r + PW'(2);
                        cnt_r    <= bus.cfg_len - 20'd1;
                        if (bus.cfg_len == 20'd1) begin
                            buf_rdy_r <= 1'b0;
                            state_r   <= ST_CLOSE;
                        end else begin
                            state_r   <= ST_CAPT;
                        end
                    end else begin
                        buf_rdy_r <= fits_s;
                        if (bus.d1_vld) begin
                            ovf_err_r <= 1'b1;
                        end
                    end
                end
                ST_CAPT: begin
                    if (bus.d1_vld) begin
                        wr_ptr_r <= wr_ptr_r + PW'(1);
                        cnt_r    <= cnt_r - 20'd1;
                        if (cnt_r == 20'd1) begin
                            buf_rdy_r <= 1'b0;
                            state_r   <= ST_CLOSE;
                        end
                    end
                end
                ST_CLOSE: begin
                    wr_cmt_r  <= wr_ptr_r;
                    seq_r     <= seq_r + 8'd1;
                    buf_rdy_r <= 1'b0;
                    state_r   <= ST_IDLE;
                    if (bus.d1_vld) begin
                        ovf_err_r <= 1'b1;
                    end
                end
                default: begin
                    buf_rdy_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM write port (storage itself is not reset).
    always_ff @(posedge clk_sys) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Read port: one committed word per accepted request, data one cycle later.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r  <= {PW{1'b0}};
            rd_vld_r  <= 1'b0;
            rd_data_r <= 16'd0;
        end else if (rd_acc_s) begin
            rd_data_r <= mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
            rd_vld_r  <= 1'b1;
            rd_ptr_r  <= rd_ptr_r + PW'(1);
        end else begin
            rd_vld_r  <= 1'b0;
        end
    end

    assign bus.buf_rdy  = buf_rdy_r;
    assign bus.ovf_err  = ovf_err_r;
    assign bus.rd_vld   = rd_vld_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_level = rd_level_s;
endmodule

// File: tb/tb_chip_frame_buf.sv
// Scoreboard bench for chip_frame_buf: frames are queued as expected read words
// when sent, and a monitor compares every rd_vld word against that queue.
module tb_chip_frame_buf;
    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    chip_frame_buf_if #(.DEPTH_LOG2(DL)) bus();
    chip_frame_buf #(.DEPTH_LOG2(DL)) dut (.clk_sys(clk_sys), .rst_n(rst_n), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          model_seq = 0;
    bit          rand_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every delivered word must be the next expected word.
    logic [15:0] mon_exp;
    always @(negedge clk_sys) begin
        if (rst_n && bus.rd_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got word %0h expected no word", bus.rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", {16'd0, bus.rd_data}, {16'd0, mon_exp});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_rdy(output bit ok);
        int n = 0;
        while (bus.buf_rdy !== 1'b1 && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        ok = (bus.buf_rdy === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: buf_rdy=%b after %0d cycles, expected 1", bus.buf_rdy, n);
        end
    endtask

    // Send one frame; its expected read image is queued once the last sample is sent.
    task automatic send_frame(input int len, input logic [6:0] sel, input bit inc, input logic [15:0] first);
        bit          ok;
        logic [15:0] d[$];
        logic [15:0] w;
        bus.cfg_len  = 20'(len);
        bus.sel_path = sel;
        cyc(2);
        wait_rdy(ok);
        if (!ok) return;
        for (int i = 0; i < len; i++) begin
            w = inc ? (first + 16'(i)) : 16'($urandom);
            d.push_back(w);
            bus.d1_vld  = 1'b1;
            bus.d1_data = w;
            @(negedge clk_sys);
        end
        bus.d1_vld = 1'b0;
        exp_q.push_back({1'b1, sel, 8'(model_seq)});
        model_seq = (model_seq + 1) % 256;
        foreach (d[i]) exp_q.push_back(d[i]);
    endtask

    // With no traffic in flight, level equals pending words and ready follows free space.
    task automatic check_quiet(input int cfg);
        int   sz;
        logic e_rdy;
        cyc(3);
        sz    = exp_q.size();
        e_rdy = (cfg != 0) && ((DEPTH - sz) >= (cfg + 1));
        chk("rd_level", 32'(bus.rd_level), 32'(sz));
        chk("buf_rdy", {31'd0, bus.buf_rdy}, {31'd0, e_rdy});
    endtask

    task automatic drain();
        int n = 0;
        bus.rd_en = 1'b1;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        bus.rd_en = 1'b0;
        cyc(3);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit ok;
        bus.d1_data  = 16'd0;
        bus.d1_vld   = 1'b0;
        bus.sel_path = 7'd3;
        bus.cfg_len  = 20'd4;
        bus.rd_en    = 1'b0;
        cyc(3);
        chk("rst_rd_level", 32'(bus.rd_level), 32'd0);
        chk("rst_buf_rdy", {31'd0, bus.buf_rdy}, 32'd0);
        chk("rst_rd_vld", {31'd0, bus.rd_vld}, 32'd0);
        chk("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf_err}, 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("rdy_first", {31'd0, bus.buf_rdy}, 32'd1);

        // Basic 4-sample frame and its commit/re-arm timing.
        send_frame(4, 7'd3, 1'b1, 16'h0100);
        chk("rdy_after_last", {31'd0, bus.buf_rdy}, 32'd0);
        cyc(1);
        chk("level_after_close", 32'(bus.rd_level), 32'd5);
        chk("rdy_in_close_gap", {31'd0, bus.buf_rdy}, 32'd0);
        cyc(1);
        chk("rdy_rearm", {31'd0, bus.buf_rdy}, 32'd1);
        drain();

        // Length boundaries on an empty buffer.
        bus.cfg_len = 20'd1023; check_quiet(1023);
        bus.cfg_len = 20'd1024; check_quiet(1024);
        bus.cfg_len = 20'd0;    check_quiet(0);

        // Large frame, then single-word reads until it fits again.
        send_frame(600, 7'($urandom), 1'b0, 16'd0);
        check_quiet(600);
        for (int r = 0; r < 600; r++) begin
            bus.rd_en = 1'b1;
            cyc(1);
            bus.rd_en = 1'b0;
            check_quiet(600);
        end
        drain();

        // Sequence wrap with a continuously draining reader.
        bus.rd_en = 1'b1;
        for (int f = 0; f < 257; f++) send_frame(1, 7'($urandom), 1'b0, 16'd0);
        drain();
        chk("ovf_after_wrap", {31'd0, bus.ovf_err}, 32'd0);
        check_quiet(1);

        // Random lengths/channels against a random reader.
        rand_done = 0;
        fork
            begin
                for (int f = 0; f < 40; f++)
                    send_frame(int'($urandom_range(1, 60)), 7'($urandom), 1'b0, 16'd0);
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    bus.rd_en = 1'($urandom_range(0, 1));
                    @(negedge clk_sys);
                end
            end
        join
        drain();
        chk("ovf_after_random", {31'd0, bus.ovf_err}, 32'd0);

        // Sample while not ready: dropped and flagged.
        bus.cfg_len = 20'd0;
        cyc(3);
        chk("rdy_len0", {31'd0, bus.buf_rdy}, 32'd0);
        bus.d1_vld  = 1'b1;
        bus.d1_data = 16'hDEAD;
        cyc(1);
        bus.d1_vld = 1'b0;
        cyc(1);
        chk("ovf_set", {31'd0, bus.ovf_err}, 32'd1);
        check_quiet(0);
        cyc(5);
        chk("ovf_sticky", {31'd0, bus.ovf_err}, 32'd1);

        // Reset in the middle of a frame, then a clean frame with seq restarted.
        bus.cfg_len  = 20'd8;
        bus.sel_path = 7'd5;
        cyc(3);
        wait_rdy(ok);
        for (int i = 0; i < 2; i++) begin
            bus.d1_vld  = 1'b1;
            bus.d1_data = 16'h0500 + 16'(i);
            @(negedge clk_sys);
        end
        rst_n      = 1'b0;
        bus.d1_vld = 1'b0;
        exp_q.delete();
        model_seq = 0;
        #1;
        chk("midrst_level", 32'(bus.rd_level), 32'd0);
        chk("midrst_rdy", {31'd0, bus.buf_rdy}, 32'd0);
        chk("midrst_ovf", {31'd0, bus.ovf_err}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        send_frame(8, 7'd5, 1'b1, 16'h0A00);
        drain();
        check_quiet(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
